// File: rtl/clkgen_frac_multi.sv
// NUM_CLOCKS fractional clock-enable channels at refclk*num/den, each with a toggled square wave.
// Reprogramming a channel re-settles and phase-aligns every channel before locked returns.
module clkgen_frac_multi #(
  parameter int NUM_CLOCKS  = 4,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CLOCKS*ACC_W-1:0] DEF_NUM = {NUM_CLOCKS{16'd1}},
  parameter logic [NUM_CLOCKS*ACC_W-1:0] DEF_DEN = {NUM_CLOCKS{16'd3}}
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_sel,
  input  logic [ACC_W-1:0]      cfg_num,
  input  logic [ACC_W-1:0]      cfg_den,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] ce,
  output logic [NUM_CLOCKS-1:0] clk_out,
  output logic                  locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic {SETTLE, RUN} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-1:0]        num [NUM_CLOCKS];
  logic [ACC_W-1:0]        den [NUM_CLOCKS];
  logic [ACC_W-1:0]        acc [NUM_CLOCKS];
  logic [ACC_W:0]          sum [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0]   hit;
  logic                    xfer;
  logic                    cfg_ok;

  // cfg_ready is only high in RUN, so a transfer can never land during SETTLE.
  assign xfer   = cfg_valid && cfg_ready;
  assign cfg_ok = ({1'b0, cfg_sel} < 5'(NUM_CLOCKS)) && (cfg_num != '0) && (cfg_num <= cfg_den);

  // One extra bit keeps acc + num exact even when both are near full scale.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, num[i]};
      hit[i] = (sum[i] >= {1'b0, den[i]});
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SETTLE;
      cnt       <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      ce        <= '0;
      clk_out   <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        num[i] <= DEF_NUM[i*ACC_W +: ACC_W];
        den[i] <= DEF_DEN[i*ACC_W +: ACC_W];
        acc[i] <= '0;
      end
    end else begin
      cfg_err <= 1'b0;
      case (state)
        SETTLE: begin
          ce      <= '0;
          clk_out <= '0;
          for (int i = 0; i < NUM_CLOCKS; i++) acc[i] <= '0;
          if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            state     <= RUN;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (xfer && cfg_ok) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
              if (cfg_sel == 4'(i)) begin
                num[i] <= cfg_num;
                den[i] <= cfg_den;
              end
              acc[i] <= '0;
            end
            state     <= SETTLE;
            cnt       <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            ce        <= '0;
            clk_out   <= '0;
          end else begin
            cfg_err <= xfer;
            for (int i = 0; i < NUM_CLOCKS; i++)
              acc[i] <= hit[i] ? ACC_W'(sum[i] - {1'b0, den[i]}) : sum[i][ACC_W-1:0];
            ce      <= hit;
            clk_out <= clk_out ^ hit;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clkgen_frac_multi.sv
// Scoreboarded bench for clkgen_frac_multi; expected outputs come from a closed-form floor(k*num/den) model.
module tb_clkgen_frac_multi;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int LC = 16;

  logic          refclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [3:0]    cfg_sel = '0;
  logic [AW-1:0] cfg_num = '0;
  logic [AW-1:0] cfg_den = '0;
  logic          cfg_ready;
  logic          cfg_err;
  logic          locked;
  logic [NC-1:0] ce;
  logic [NC-1:0] clk_out;

  always #5 refclk = ~refclk;

  clkgen_frac_multi #(
    .NUM_CLOCKS (NC),
    .ACC_W      (AW),
    .LOCK_CYCLES(LC),
    .DEF_NUM    ({NC{16'd1}}),
    .DEF_DEN    ({NC{16'd3}})
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel  (cfg_sel),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .cfg_err  (cfg_err),
    .ce       (ce),
    .clk_out  (clk_out),
    .locked   (locked)
  );

  typedef struct packed {
    logic [NC-1:0] ce;
    logic [NC-1:0] clk;
    logic          locked;
    logic          ready;
    logic          err;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: a channel running for k edges has emitted floor(k*num/den) enables.
  bit     m_run;
  int     m_scnt;
  longint m_k;
  longint m_num[NC];
  longint m_den[NC];

  function automatic void model_reset();
    m_run  = 1'b0;
    m_scnt = 0;
    m_k    = 0;
    for (int i = 0; i < NC; i++) begin
      m_num[i] = 1;
      m_den[i] = 3;
    end
  endfunction

  task automatic model_step();
    obs_t   e;
    bit     good;
    longint q0, q1;
    e = '0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_run) begin
      if (m_scnt == LC - 1) begin
        m_run    = 1'b1;
        m_k      = 0;
        e.locked = 1'b1;
        e.ready  = 1'b1;
      end else begin
        m_scnt++;
      end
    end else begin
      good = (cfg_sel < NC) && (cfg_num != 0) && (cfg_num <= cfg_den);
      if (cfg_valid && good) begin
        m_num[cfg_sel] = cfg_num;
        m_den[cfg_sel] = cfg_den;
        m_run  = 1'b0;
        m_scnt = 0;
      end else begin
        m_k++;
        e.locked = 1'b1;
        e.ready  = 1'b1;
        e.err    = cfg_valid;
        for (int i = 0; i < NC; i++) begin
          q1 = (m_k * m_num[i]) / m_den[i];
          q0 = ((m_k - 1) * m_num[i]) / m_den[i];
          e.ce[i]  = (q1 != q0);
          e.clk[i] = q1[0];
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per edge, compared half a cycle later.
  initial begin
    forever begin
      @(negedge refclk);
      cyc++;
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a = {ce, clk_out, locked, cfg_ready, cfg_err};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got ce=%b clk_out=%b locked=%b ready=%b err=%b, want ce=%b clk_out=%b locked=%b ready=%b err=%b",
                   cyc, a.ce, a.clk, a.locked, a.ready, a.err, e.ce, e.clk, e.locked, e.ready, e.err);
        end
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge refclk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send_cfg(input int sel, input int n, input int d);
    bit hs;
    cfg_sel   = 4'(sel);
    cfg_num   = AW'(n);
    cfg_den   = AW'(d);
    cfg_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      hs = cfg_ready;
      tick();
      if (hs) begin
        cfg_valid = 1'b0;
        return;
      end
    end
    cfg_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL cfg handshake: got no cfg_ready within 200 cycles, want acceptance");
  endtask

  task automatic wait_lock();
    for (int t = 0; t < 200; t++) begin
      if (locked) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL lock wait: got locked=0 after 200 cycles, want 1");
  endtask

  task automatic count_ce(input int ch, input int n, input int want, input string name);
    int cnt;
    cnt = 0;
    repeat (n) begin
      tick();
      cnt += int'(ce[ch]);
    end
    checks++;
    if (cnt != want) begin
      errors++;
      $display("FAIL %s: got %0d ce pulses, want %0d", name, cnt, want);
    end
  endtask

  task automatic check_zero(input string name);
    logic [2*NC+2:0] a;
    a = {ce, clk_out, locked, cfg_ready, cfg_err};
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL %s: got outputs %b, want all zero", name, a);
    end
  endtask

  task automatic async_reset(input string name);
    @(negedge refclk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero(name);
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    run(2);
    check_zero("reset_state");
    rst_n = 1'b1;
    run(LC + 30);

    // 2/5 on channel 1: 200 pulses in 500 RUN cycles
    send_cfg(1, 2, 5);
    wait_lock();
    count_ce(1, 500, 200, "ch1_2of5_count");

    send_cfg(2, 7, 7);
    wait_lock();
    count_ce(2, 20, 20, "ch2_7of7_count");

    // rejected configs
    send_cfg(0, 0, 5);
    run(3);
    send_cfg(0, 6, 5);
    run(3);
    send_cfg(NC, 1, 2);
    run(5);

    // second request held through SETTLE
    send_cfg(0, 1, 2);
    send_cfg(3, 3, 4);
    run(20);

    for (int r = 0; r < 12; r++) begin
      int d;
      d = $urandom_range(12, 1);
      send_cfg($urandom_range(5, 0), $urandom_range(d + 1, 0), d);
      run($urandom_range(40, 0));
    end

    // reset at SETTLE counter 8 after reprogram, defaults must return
    wait_lock();
    send_cfg(2, 3, 4);
    run(8);
    async_reset("reset_mid_settle");
    wait_lock();
    run(4);
    async_reset("reset_mid_run");
    run(LC + 20);

    // full-scale numerators and denominators
    send_cfg(3, 65535, 65535);
    wait_lock();
    count_ce(3, 30, 30, "ch3_full_scale");
    send_cfg(0, 40000, 65535);
    wait_lock();
    run(60);
    send_cfg(1, 3, 65535);
    wait_lock();
    count_ce(1, 21845, 1, "ch1_3of65535");
    run(10);

    @(negedge refclk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
